ysyx_25040109_trap_ctrl: RTL and testbench

Trap sequencer for the single-cycle NPC. Sits between decode/commit and the register file's single CSR write port. Executes `ecall` and `mret` as multi-cycle CSR sequences, stalling commit while it runs. Passes ordinary CSR-instruction writes through when idle, then redirects the PC to `mtvec` or `mepc`.

---
 rtl/ysyx_25040109_trap_pkg.sv | 47 ++++
 rtl/ysyx_25040109_trap_ctrl.sv | 129 ++++++++++++
 tb/tb_ysyx_25040109_trap_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25040109_trap_pkg.sv
// Shared definitions for the trap sequencer.
// Covers the CSR addresses, FSM states, mstatus field positions and mstatus update helpers.
package ysyx_25040109_trap_pkg;

    localparam int XLEN = 32;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_T_EPC    = 3'd1,
        ST_T_CAUSE  = 3'd2,
        ST_T_STATUS = 3'd3,
        ST_T_JUMP   = 3'd4,
        ST_M_STATUS = 3'd5,
        ST_M_JUMP   = 3'd6
    } trap_state_t;

    // Trap entry: stash MIE into MPIE, disable interrupts, record M-mode as previous privilege.
    function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] status);
        logic [XLEN-1:0] result;
        result                                = status;
        result[MSTATUS_MPIE]                  = status[MSTATUS_MIE];
        result[MSTATUS_MIE]                   = 1'b0;
        result[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return result;
    endfunction

    // Trap return: restore MIE from MPIE, then set MPIE and keep MPP at M-mode.
    function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] status);
        logic [XLEN-1:0] result;
        result                                = status;
        result[MSTATUS_MIE]                   = status[MSTATUS_MPIE];
        result[MSTATUS_MPIE]                  = 1'b1;
        result[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return result;
    endfunction

endpackage

// File: rtl/ysyx_25040109_trap_ctrl.sv
// Trap sequencer: runs ecall/mret as multi-cycle CSR write sequences on the single CSR port,
// passes ordinary CSR writes through while idle, and issues the PC redirect at the end.
module ysyx_25040109_trap_ctrl
    import ysyx_25040109_trap_pkg::*;
#(
    parameter int unsigned              DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0]    ECALL_CAUSE = 32'd11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_valid,
    input  logic                  is_ecall,
    input  logic                  is_mret,
    input  logic                  is_csr_wr,
    input  logic [11:0]           csr_addr_in,
    input  logic [DATA_WIDTH-1:0] csr_wdata_in,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    input  logic [DATA_WIDTH-1:0] mtvec_in,
    input  logic [DATA_WIDTH-1:0] mepc_in,
    output logic                  csr_we,
    output logic [11:0]           csr_addr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    output logic                  stall,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc
);

    trap_state_t           state_reg;
    trap_state_t           state_next;
    logic [DATA_WIDTH-1:0] pc_q_reg;
    logic [DATA_WIDTH-1:0] pc_q_next;

    logic                  take_ecall;
    logic                  take_mret;
    logic                  take_csr_wr;
    logic [DATA_WIDTH-1:0] status_trap;
    logic [DATA_WIDTH-1:0] status_mret;
    logic [DATA_WIDTH-1:0] mtvec_base;

    // Priority resolution: ecall wins over mret, which wins over a plain CSR write.
    assign take_ecall  = inst_valid & is_ecall;
    assign take_mret   = inst_valid & ~is_ecall & is_mret;
    assign take_csr_wr = inst_valid & ~is_ecall & ~is_mret & is_csr_wr;

    assign status_trap = DATA_WIDTH'(mstatus_on_trap(XLEN'(csr_rdata)));
    assign status_mret = DATA_WIDTH'(mstatus_on_mret(XLEN'(csr_rdata)));
    assign mtvec_base  = {mtvec_in[DATA_WIDTH-1:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            pc_q_reg  <= '0;
        end else begin
            state_reg <= state_next;
            pc_q_reg  <= pc_q_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pc_q_next      = pc_q_reg;
        csr_we         = 1'b0;
        csr_addr       = csr_addr_in;
        csr_wdata      = '0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        case (state_reg)
            ST_IDLE: begin
                if (take_ecall) begin
                    stall      = 1'b1;
                    pc_q_next  = pc;
                    state_next = ST_T_EPC;
                end else if (take_mret) begin
                    stall      = 1'b1;
                    state_next = ST_M_STATUS;
                end else if (take_csr_wr) begin
                    csr_we    = 1'b1;
                    csr_wdata = csr_wdata_in;
                end
            end
            ST_T_EPC: begin
                stall      = 1'b1;
                csr_we     = 1'b1;
                csr_addr   = CSR_MEPC;
                csr_wdata  = pc_q_reg;
                state_next = ST_T_CAUSE;
            end
            ST_T_CAUSE: begin
                stall      = 1'b1;
                csr_we     = 1'b1;
                csr_addr   = CSR_MCAUSE;
                csr_wdata  = ECALL_CAUSE;
                state_next = ST_T_STATUS;
            end
            ST_T_STATUS: begin
                stall      = 1'b1;
                csr_we     = 1'b1;
                csr_addr   = CSR_MSTATUS;
                csr_wdata  = status_trap;
                state_next = ST_T_JUMP;
            end
            ST_T_JUMP: begin
                // Only direct mode is supported, so the mode bits are simply masked off.
                redirect_valid = 1'b1;
                redirect_pc    = mtvec_base;
                state_next     = ST_IDLE;
            end
            ST_M_STATUS: begin
                stall      = 1'b1;
                csr_we     = 1'b1;
                csr_addr   = CSR_MSTATUS;
                csr_wdata  = status_mret;
                state_next = ST_M_JUMP;
            end
            ST_M_JUMP: begin
                redirect_valid = 1'b1;
                redirect_pc    = mepc_in;
                state_next     = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_25040109_trap_ctrl.sv
// Bench for the trap sequencer: a small CSR register-file model feeds the DUT, a vector table
// plus a few hand sequences push per-cycle expectations into a scoreboard checked on negedge.
module tb_ysyx_25040109_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic        is_ecall;
    logic        is_mret;
    logic        is_csr_wr;
    logic [11:0] csr_addr_in;
    logic [31:0] csr_wdata_in;
    logic [31:0] pc;
    logic [31:0] csr_rdata;
    logic [31:0] mtvec_in;
    logic [31:0] mepc_in;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    ysyx_25040109_trap_ctrl #(
        .DATA_WIDTH  (32),
        .ECALL_CAUSE (32'd11)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_valid     (inst_valid),
        .is_ecall       (is_ecall),
        .is_mret        (is_mret),
        .is_csr_wr      (is_csr_wr),
        .csr_addr_in    (csr_addr_in),
        .csr_wdata_in   (csr_wdata_in),
        .pc             (pc),
        .csr_rdata      (csr_rdata),
        .mtvec_in       (mtvec_in),
        .mepc_in        (mepc_in),
        .csr_we         (csr_we),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // Register-file model with a preload port for setting up each transaction.
    logic [31:0] m_status, m_tvec, m_epc, m_cause;
    logic        load_en;
    logic [31:0] ld_status, ld_tvec, ld_epc, ld_cause;

    always @(posedge clk) begin
        if (load_en) begin
            m_status <= ld_status;
            m_tvec   <= ld_tvec;
            m_epc    <= ld_epc;
            m_cause  <= ld_cause;
        end else if (csr_we) begin
            case (csr_addr)
                12'h300: m_status <= csr_wdata;
                12'h305: m_tvec   <= csr_wdata;
                12'h341: m_epc    <= csr_wdata;
                12'h342: m_cause  <= csr_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            12'h300: csr_rdata = m_status;
            12'h305: csr_rdata = m_tvec;
            12'h341: csr_rdata = m_epc;
            12'h342: csr_rdata = m_cause;
            default: csr_rdata = '0;
        endcase
    end

    assign mtvec_in = m_tvec;
    assign mepc_in  = m_epc;

    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        chk_addr;
    } exp_t;

    typedef struct packed {
        logic        valid;
        logic        ecall;
        logic        mret;
        logic        csrw;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [31:0] st;
        logic [31:0] tv;
        logic [31:0] ep;
        logic [31:0] exp_status;
        logic [31:0] exp_target;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic valid, input logic ecall, input logic mret,
                                input logic csrw, input logic [11:0] addr,
                                input logic [31:0] wdata, input logic [31:0] pcv,
                                input logic [31:0] st, input logic [31:0] tv,
                                input logic [31:0] ep, input logic [31:0] es,
                                input logic [31:0] et);
        vec_t v;
        v.valid = valid; v.ecall = ecall; v.mret = mret; v.csrw = csrw;
        v.addr = addr; v.wdata = wdata; v.pc = pcv;
        v.st = st; v.tv = tv; v.ep = ep;
        v.exp_status = es; v.exp_target = et;
        return v;
    endfunction

    task automatic push_exp(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                            input logic st, input logic rv, input logic [31:0] rpc,
                            input logic chk_addr);
        exp_t e;
        e.we = we; e.addr = addr; e.wdata = wdata; e.stall = st;
        e.rv = rv; e.rpc = rpc; e.chk_addr = chk_addr;
        sb.push_back(e);
    endtask

    task automatic check_cycle(input exp_t e, input int vi, input int cyc);
        logic ok;
        ok = (csr_we === e.we) && (csr_wdata === e.wdata) && (stall === e.stall) &&
             (redirect_valid === e.rv) && (redirect_pc === e.rpc) &&
             (!e.chk_addr || (csr_addr === e.addr));
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL outputs vec=%0d cyc=%0d got we=%b addr=%h wdata=%h stall=%b rv=%b rpc=%h want we=%b addr=%h wdata=%h stall=%b rv=%b rpc=%h",
                     vi, cyc, csr_we, csr_addr, csr_wdata, stall, redirect_valid, redirect_pc,
                     e.we, e.addr, e.wdata, e.stall, e.rv, e.rpc);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Compare one scoreboard entry at negedge, then move to just after the next posedge.
    task automatic step(input int vi, input int cyc);
        exp_t e;
        @(negedge clk);
        e = sb.pop_front();
        check_cycle(e, vi, cyc);
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        is_ecall   = 1'b0;
        is_mret    = 1'b0;
        is_csr_wr  = 1'b0;
    endtask

    task automatic drain(input int vi);
        int cyc;
        cyc = 0;
        while (sb.size() > 0) begin
            step(vi, cyc);
            cyc++;
        end
    endtask

    task automatic preload(input logic [31:0] st, input logic [31:0] tv,
                           input logic [31:0] ep, input logic [31:0] ca);
        load_en   = 1'b1;
        ld_status = st;
        ld_tvec   = tv;
        ld_epc    = ep;
        ld_cause  = ca;
        @(posedge clk);
        #1;
        load_en = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        preload(v.st, v.tv, v.ep, 32'h0);
        inst_valid   = v.valid;
        is_ecall     = v.ecall;
        is_mret      = v.mret;
        is_csr_wr    = v.csrw;
        csr_addr_in  = v.addr;
        csr_wdata_in = v.wdata;
        pc           = v.pc;
        if (v.valid && v.ecall) begin
            push_exp(1'b0, v.addr,  32'h0,        1'b1, 1'b0, 32'h0, 1'b1);
            push_exp(1'b1, 12'h341, v.pc,         1'b1, 1'b0, 32'h0, 1'b1);
            push_exp(1'b1, 12'h342, 32'd11,       1'b1, 1'b0, 32'h0, 1'b1);
            push_exp(1'b1, 12'h300, v.exp_status, 1'b1, 1'b0, 32'h0, 1'b1);
            push_exp(1'b0, 12'h000, 32'h0,        1'b0, 1'b1, v.exp_target, 1'b0);
            push_exp(1'b0, v.addr,  32'h0,        1'b0, 1'b0, 32'h0, 1'b1);
        end else if (v.valid && v.mret) begin
            push_exp(1'b0, v.addr,  32'h0,        1'b1, 1'b0, 32'h0, 1'b1);
            push_exp(1'b1, 12'h300, v.exp_status, 1'b1, 1'b0, 32'h0, 1'b1);
            push_exp(1'b0, 12'h000, 32'h0,        1'b0, 1'b1, v.exp_target, 1'b0);
            push_exp(1'b0, v.addr,  32'h0,        1'b0, 1'b0, 32'h0, 1'b1);
        end else if (v.valid && v.csrw) begin
            push_exp(1'b1, v.addr,  v.wdata,      1'b0, 1'b0, 32'h0, 1'b1);
            push_exp(1'b0, v.addr,  32'h0,        1'b0, 1'b0, 32'h0, 1'b1);
        end else begin
            push_exp(1'b0, v.addr,  32'h0,        1'b0, 1'b0, 32'h0, 1'b1);
            push_exp(1'b0, v.addr,  32'h0,        1'b0, 1'b0, 32'h0, 1'b1);
        end
        drain(vi);
        if (v.valid && v.ecall) begin
            check_val("mepc_final", m_epc, v.pc);
            check_val("mcause_final", m_cause, 32'd11);
            check_val("mstatus_final", m_status, v.exp_status);
        end else if (v.valid && v.mret) begin
            check_val("mstatus_final", m_status, v.exp_status);
        end
        $display("vec %0d: v=%b e=%b m=%b w=%b pc=%h errors so far=%0d",
                 vi, v.valid, v.ecall, v.mret, v.csrw, v.pc, errors);
    endtask

    initial begin
        //            valid ecall mret csrw addr     wdata         pc            mstatus       mtvec         mepc          exp_status    exp_target
        vecs.push_back(mk(1, 1, 0, 0, 12'h000, 32'h0,        32'h80000010, 32'h00001808, 32'h80000100, 32'h0,        32'h00001880, 32'h80000100));
        vecs.push_back(mk(1, 0, 1, 0, 12'h000, 32'h0,        32'h0,        32'h00001880, 32'h80000100, 32'h80000014, 32'h00001888, 32'h80000014));
        vecs.push_back(mk(1, 1, 0, 0, 12'h000, 32'h0,        32'h80000020, 32'h00000000, 32'h80000103, 32'h0,        32'h00001800, 32'h80000100));
        vecs.push_back(mk(1, 1, 1, 1, 12'h305, 32'hDEADBEEF, 32'h80000040, 32'hFFFFFFFF, 32'h80000200, 32'h0,        32'hFFFFFFF7, 32'h80000200));
        vecs.push_back(mk(1, 0, 1, 0, 12'h000, 32'h0,        32'h0,        32'hA0000008, 32'h80000100, 32'h80001000, 32'hA0001880, 32'h80001000));
        vecs.push_back(mk(1, 0, 0, 1, 12'h342, 32'h12345678, 32'h0,        32'h00000000, 32'h80000100, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 1, 1, 12'h341, 32'h55555555, 32'h0,        32'h00000080, 32'h80000100, 32'h80000300, 32'h00001888, 32'h80000300));
        vecs.push_back(mk(0, 1, 1, 1, 12'h300, 32'h11111111, 32'h80000060, 32'h00001808, 32'h80000100, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 12'h341, 32'h22222222, 32'h80000070, 32'h00001808, 32'h80000100, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(1, 1, 0, 0, 12'h000, 32'h0,        32'h80000080, 32'h00000080, 32'h80000400, 32'h0,        32'h00001800, 32'h80000400));

        rst          = 1'b1;
        inst_valid   = 1'b0;
        is_ecall     = 1'b0;
        is_mret      = 1'b0;
        is_csr_wr    = 1'b0;
        csr_addr_in  = 12'h123;
        csr_wdata_in = 32'h0;
        pc           = 32'h0;
        load_en      = 1'b0;
        ld_status    = '0;
        ld_tvec      = '0;
        ld_epc       = '0;
        ld_cause     = '0;

        // Outputs while held in reset.
        repeat (2) @(posedge clk);
        push_exp(1'b0, 12'h123, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check_cycle(sb.pop_front(), -1, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // csrw mepc immediately followed by mret: the jump must see the new mepc.
        preload(32'h00001880, 32'h80000100, 32'h80000010, 32'h0);
        inst_valid   = 1'b1;
        is_csr_wr    = 1'b1;
        csr_addr_in  = 12'h341;
        csr_wdata_in = 32'h80000200;
        push_exp(1'b1, 12'h341, 32'h80000200, 1'b0, 1'b0, 32'h0, 1'b1);
        step(100, 0);
        inst_valid  = 1'b1;
        is_mret     = 1'b1;
        csr_addr_in = 12'h000;
        push_exp(1'b0, 12'h000, 32'h0,        1'b1, 1'b0, 32'h0, 1'b1);
        push_exp(1'b1, 12'h300, 32'h00001888, 1'b1, 1'b0, 32'h0, 1'b1);
        push_exp(1'b0, 12'h000, 32'h0,        1'b0, 1'b1, 32'h80000200, 1'b0);
        push_exp(1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 32'h0, 1'b1);
        drain(100);
        $display("seq csrw_then_mret: errors so far=%0d", errors);

        // Reset asserted while the sequencer sits in T_CAUSE.
        preload(32'h00001808, 32'h80000100, 32'h0, 32'h5);
        inst_valid  = 1'b1;
        is_ecall    = 1'b1;
        pc          = 32'h80000050;
        csr_addr_in = 12'h000;
        push_exp(1'b0, 12'h000, 32'h0,        1'b1, 1'b0, 32'h0, 1'b1);
        push_exp(1'b1, 12'h341, 32'h80000050, 1'b1, 1'b0, 32'h0, 1'b1);
        drain(101);
        rst = 1'b1;
        #1;
        push_exp(1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_cycle(sb.pop_front(), 101, 2);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            push_exp(1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        end
        drain(102);
        check_val("rst_mid_mepc", m_epc, 32'h80000050);
        check_val("rst_mid_mcause", m_cause, 32'h5);
        check_val("rst_mid_mstatus", m_status, 32'h00001808);
        $display("seq reset_in_t_cause: errors so far=%0d", errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
